// File: rtl/serial_lu_pkg.sv
// serial_lu_pkg: shared op encodings and FSM state encoding for the
// bit-serial logic unit (serial_lu_ctrl and its lu_slice).
package serial_lu_pkg;

  // Operation select encodings driven on the op port.
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  // Controller states: wait for a bundle, shift bits through the slice,
  // present the result until the consumer takes it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_lu_ctrl_slice.sv
// lu_slice: combinational 1-bit logic slice; evaluates one bit of the
// selected operation. Operand B is a don't-care for OP_NOTA.
import serial_lu_pkg::*;

module lu_slice (
  input  logic [1:0] op,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic       r_bit
);

  // One-bit evaluation of the op table.
  always_comb begin
    r_bit = 1'b0;
    case (op)
      OP_AND:  r_bit = a_bit & b_bit;
      OP_OR:   r_bit = a_bit | b_bit;
      OP_XOR:  r_bit = a_bit ^ b_bit;
      OP_NOTA: r_bit = ~a_bit;
      default: r_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_lu_ctrl.sv
// serial_lu_ctrl: bit-serial logic unit controller.
// Handshake: a bundle (a, b, op) transfers on a rising edge where
// in_valid && in_ready; a result transfers on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE, out_valid only
// in DONE, and res is held stable for as long as out_valid is high.
// Optional feature macro: SERIAL_LU_ZFLAG_EN adds the 'zero' output,
// high in DONE when the result is all zeros.
import serial_lu_pkg::*;

module serial_lu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
`ifdef SERIAL_LU_ZFLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             r_bit;

  // The single slice always sees the current LSBs of the operand shifters.
  lu_slice u_slice (
    .op    (op_q),
    .a_bit (a_sh_q[0]),
    .b_bit (b_sh_q[0]),
    .r_bit (r_bit)
  );

  // Next-state and datapath updates; everything holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Operands drain LSB first; results enter at the MSB so that
        // after WIDTH shifts bit i sits at res[i].
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {r_bit, res_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    res       = res_q;
  end

`ifdef SERIAL_LU_ZFLAG_EN
  // Zero flag is only meaningful alongside out_valid.
  always_comb begin
    zero = (state_q == ST_DONE) && (res_q == '0);
  end
`endif

endmodule

// File: tb/tb_serial_lu_ctrl.sv
// tb_serial_lu_ctrl: randomized and directed stimulus for serial_lu_ctrl
// (WIDTH=8) against a word-level reference model with an expected queue.
module tb_serial_lu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;
`ifdef SERIAL_LU_ZFLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  serial_lu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
`ifdef SERIAL_LU_ZFLAG_EN
    ,
    .zero      (zero)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Word-level reference: the whole operation at once.
  function automatic logic [W-1:0] ref_op(input logic [1:0] o,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~x;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, serial run, optional DONE backpressure,
  // release. scramble toggles inputs every cycle after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int hold,
                        input bit scramble);
    int lat;
    logic [W-1:0] expv;
    logic [W-1:0] held;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    op = o; a = x; b = y; in_valid = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(ref_op(o, x, y));
    step();
    in_valid = 1'b0;
    lat = 1;
    check("run_in_ready", in_ready, 0);
    while (!out_valid && lat < 4 * W) begin
      if (scramble) begin
        a = W'($urandom); b = W'($urandom);
        op = 2'($urandom_range(0, 3));
        in_valid = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("timeout_out_valid", 0, 1);
      return;
    end
    check("latency", lat, W + 1);
    expv = exp_q.pop_front();
    check("res", res, expv);
    check("done_in_ready", in_ready, 0);
`ifdef SERIAL_LU_ZFLAG_EN
    check("zero", zero, (expv == '0));
`endif
    held = res;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom);
      step();
      check("hold_out_valid", out_valid, 1);
      check("hold_res", res, held);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 0);
`ifdef SERIAL_LU_ZFLAG_EN
    check("rst_zero", zero, 0);
`endif
    rst_n = 1'b1;
    step();

    // Directed operations
    run_op(2'd0, 8'hA5, 8'h3C, 0, 0);
    run_op(2'd1, 8'hA5, 8'h3C, 0, 0);
    run_op(2'd2, 8'hA5, 8'h3C, 0, 0);
    run_op(2'd3, 8'hA5, 8'hFF, 0, 0);
    run_op(2'd3, 8'hA5, 8'h00, 0, 0);
    // Backpressure in DONE
    run_op(2'd0, 8'hA5, 8'h3C, 5, 0);
    // Inputs changing every cycle after acceptance
    run_op(2'd1, 8'h12, 8'h40, 0, 1);
    // Zero-result and nonzero-result cases
    run_op(2'd2, 8'h55, 8'h55, 0, 0);
    run_op(2'd1, 8'h00, 8'h01, 0, 0);

    // Reset mid-RUN discards the operation; in_valid during reset ignored
    op = 2'd0; a = 8'hA5; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    in_valid = 1'b1;
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_res", res, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 2 * W; i++) begin
        step();
        if (out_valid) seen++;
      end
      check("midrst_no_pulse", seen, 0);
    end
    out_ready = 1'b0;
    run_op(2'd2, 8'h0F, 8'hFF, 0, 0);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
